// File: rtl/mem_1r1w_ctrl_32x136.sv
// mem_1r1w_ctrl_32x136: zero-fills a 32x136 masked 1R1W macro, then round-robin arbitrates two writers and forwards same-address writes into 1-cycle read responses
module mem_1r1w_ctrl_32x136 (
  input  logic         clk,
  input  logic         rst_n,
  output logic         init_done,
  input  logic         wa_valid,
  output logic         wa_ready,
  input  logic [4:0]   wa_addr,
  input  logic [135:0] wa_data,
  input  logic [16:0]  wa_mask,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [4:0]   wb_addr,
  input  logic [135:0] wb_data,
  input  logic [16:0]  wb_mask,
  input  logic         rd_valid,
  output logic         rd_ready,
  input  logic [4:0]   rd_addr,
  output logic         rsp_valid,
  output logic [135:0] rsp_data,
  output logic [4:0]   R0_addr,
  output logic         R0_en,
  input  logic [135:0] R0_data,
  output logic [4:0]   W0_addr,
  output logic         W0_en,
  output logic [135:0] W0_data,
  output logic [16:0]  W0_mask
);
  localparam int MG = 8;
  localparam int MW = 17;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [4:0] init_ptr, init_ptr_n;
  logic rr_ptr, rr_ptr_n;
  logic in_run, grant_a, grant_b, rd_fire, fwd, hit;
  logic [135:0] hit_data, rsp_hold, merged;
  logic [MW-1:0] hit_mask;
  always_comb begin
    in_run = state == RUN;
    grant_a = in_run & wa_valid & (~wb_valid | ~rr_ptr);
    grant_b = in_run & wb_valid & (~wa_valid | rr_ptr);
    rd_fire = in_run & rd_valid;
    state_n = (!in_run && init_ptr == '1) ? RUN : state;
    init_ptr_n = in_run ? init_ptr : init_ptr + 1'b1;
    rr_ptr_n = rr_ptr ^ (in_run & wa_valid & wb_valid);
    init_done = in_run;
    wa_ready = grant_a;
    wb_ready = grant_b;
    rd_ready = in_run;
    R0_en = rd_fire;
    R0_addr = rd_addr;
    // rst_n gating keeps the zero-fill write quiet while reset is held
    W0_en = (~in_run & rst_n) | grant_a | grant_b;
    W0_addr = in_run ? (grant_b ? wb_addr : wa_addr) : init_ptr;
    W0_data = in_run ? (grant_b ? wb_data : wa_data) : '0;
    W0_mask = in_run ? (grant_b ? wb_mask : wa_mask) : '1;
    // macro reads return pre-write data, so a same-cycle write must be overlaid next cycle
    fwd = rd_fire & (grant_a | grant_b) & (W0_addr == rd_addr);
    merged = R0_data;
    for (int i = 0; i < MW; i++)
      merged[i*MG +: MG] = (hit & hit_mask[i]) ? hit_data[i*MG +: MG] : R0_data[i*MG +: MG];
    rsp_data = rsp_valid ? merged : rsp_hold;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      init_ptr <= '0;
      rr_ptr <= 1'b0;
      rsp_valid <= 1'b0;
      hit <= 1'b0;
      hit_data <= '0;
      hit_mask <= '0;
      rsp_hold <= '0;
    end else begin
      state <= state_n;
      init_ptr <= init_ptr_n;
      rr_ptr <= rr_ptr_n;
      rsp_valid <= rd_fire;
      hit <= fwd;
      if (fwd) begin
        hit_data <= W0_data;
        hit_mask <= W0_mask;
      end
      if (rsp_valid) rsp_hold <= rsp_data;
    end
  end
endmodule

// File: tb/tb_mem_1r1w_ctrl_32x136.sv
// tb_mem_1r1w_ctrl_32x136: directed bench with a memory-level reference model for the 32x136 1R1W controller
module tb_mem_1r1w_ctrl_32x136;
  logic clk = 1'b0;
  logic rst_n;
  logic init_done;
  logic wa_valid, wa_ready, wb_valid, wb_ready, rd_valid, rd_ready, rsp_valid;
  logic [4:0] wa_addr, wb_addr, rd_addr, R0_addr, W0_addr;
  logic [135:0] wa_data, wb_data, rsp_data, R0_data, W0_data;
  logic [16:0] wa_mask, wb_mask, W0_mask;
  logic R0_en, W0_en;
  always #5 clk = ~clk;
  mem_1r1w_ctrl_32x136 dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data), .wa_mask(wa_mask),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .wb_mask(wb_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
  );
  // macro stand-in: synchronous read-first 1R1W with byte-lane write mask, seeded with garbage
  logic [135:0] mac [32];
  logic [135:0] r0_q;
  logic seeded = 1'b0;
  assign R0_data = r0_q;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) mac[i] <= {8'(i), {4{$urandom()}}};
      seeded <= 1'b1;
    end else begin
      if (R0_en) r0_q <= mac[R0_addr];
      if (W0_en)
        for (int l = 0; l < 17; l++)
          if (W0_mask[l]) mac[W0_addr][l*8 +: 8] <= W0_data[l*8 +: 8];
    end
  end
  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [135:0] merge(input logic [135:0] o, input logic [135:0] d, input logic [16:0] m);
    for (int l = 0; l < 17; l++) if (m[l]) o[l*8 +: 8] = d[l*8 +: 8];
    return o;
  endfunction
  // reference model: contents as the spec defines them, plus pending response and arbitration turn
  logic [135:0] gold [32];
  int m_init = 0;
  logic m_rr = 1'b0;
  logic m_pend = 1'b0;
  logic [135:0] m_pd = '0, m_last = '0, exp_rsp;
  logic ga, gb;
  logic [4:0] wad;
  logic [135:0] wd;
  logic [16:0] wm;
  logic grant_log [$];
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_init_done", init_done, 0);
      chk("rst_wa_ready", wa_ready, 0);
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_R0_en", R0_en, 0);
      chk("rst_W0_en", W0_en, 0);
      m_init = 0; m_rr = 1'b0; m_pend = 1'b0; m_last = '0;
    end else if (m_init < 32) begin
      chk("init_W0_en", W0_en, 1);
      chk("init_W0_addr", W0_addr, 136'(m_init));
      chk("init_W0_data", W0_data, 0);
      chk("init_W0_mask", W0_mask, 17'h1ffff);
      chk("init_done_early", init_done, 0);
      chk("init_ready", {wa_ready, wb_ready, rd_ready}, 0);
      chk("init_R0_en", R0_en, 0);
      chk("init_rsp_valid", rsp_valid, 0);
      chk("init_rsp_data", rsp_data, m_last);
      gold[m_init] = '0;
      m_init++;
    end else begin
      ga = wa_valid && (!wb_valid || !m_rr);
      gb = wb_valid && !ga;
      wad = ga ? wa_addr : wb_addr;
      wd = ga ? wa_data : wb_data;
      wm = ga ? wa_mask : wb_mask;
      chk("run_init_done", init_done, 1);
      chk("run_wa_ready", wa_ready, ga);
      chk("run_wb_ready", wb_ready, gb);
      chk("run_one_winner", wa_ready & wb_ready, 0);
      chk("run_W0_en", W0_en, ga | gb);
      if (ga || gb) begin
        chk("run_W0_addr", W0_addr, wad);
        chk("run_W0_data", W0_data, wd);
        chk("run_W0_mask", W0_mask, wm);
      end
      chk("run_rd_ready", rd_ready, 1);
      chk("run_R0_en", R0_en, rd_valid);
      if (rd_valid) chk("run_R0_addr", R0_addr, rd_addr);
      exp_rsp = m_pend ? m_pd : m_last;
      chk("run_rsp_valid", rsp_valid, m_pend);
      chk("run_rsp_data", rsp_data, exp_rsp);
      m_last = exp_rsp;
      m_pend = rd_valid;
      if (rd_valid) m_pd = ((ga || gb) && wad == rd_addr) ? merge(gold[rd_addr], wd, wm) : gold[rd_addr];
      if (ga || gb) begin
        gold[wad] = merge(gold[wad], wd, wm);
        grant_log.push_back(gb);
      end
      if (wa_valid && wb_valid) m_rr = !m_rr;
    end
  end
  task automatic wait_init(output int n);
    int k = 0;
    n = 0;
    while (!init_done && k < 100) begin
      @(negedge clk);
      if (W0_en && !init_done) n++;
      k++;
    end
    chk("init_done_timeout", init_done, 1);
  endtask
  task automatic rd(input logic [4:0] a, output logic [135:0] d);
    @(posedge clk); #1;
    rd_valid = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1);
    d = rsp_data;
  endtask
  task automatic wr_a(input logic [4:0] a, input logic [135:0] d, input logic [16:0] m);
    @(posedge clk); #1;
    wa_valid = 1'b1; wa_addr = a; wa_data = d; wa_mask = m;
    @(posedge clk); #1;
    wa_valid = 1'b0;
  endtask
  int n;
  logic [135:0] d;
  initial begin
    rst_n = 1'b0;
    wa_valid = 0; wa_addr = 0; wa_data = 0; wa_mask = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; wb_mask = 0;
    rd_valid = 0; rd_addr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init(n);
    chk("init_write_cycles", n, 32);
    rd(5'd7, d);
    chk("read7_zero", d, 136'h0);
    wr_a(5'd3, '1, 17'h00001);
    rd(5'd3, d);
    chk("masked_write3", d, 136'hFF);
    wr_a(5'd9, '1, 17'h0);
    rd(5'd9, d);
    chk("mask0_write9", d, 136'h0);
    @(posedge clk); #1;
    wa_valid = 1'b1; wa_addr = 5'd5; wa_data = '1; wa_mask = 17'h10001;
    rd_valid = 1'b1; rd_addr = 5'd5;
    @(posedge clk); #1;
    wa_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    chk("collide_valid", rsp_valid, 1);
    chk("collide_fwd", rsp_data, {8'hFF, 120'h0, 8'hFF});
    @(posedge clk); #1;
    grant_log.delete();
    wa_valid = 1'b1; wa_addr = 5'd10; wa_data = {17{8'hA5}}; wa_mask = 17'h0F0F0;
    wb_valid = 1'b1; wb_addr = 5'd20; wb_data = {17{8'h3C}}; wb_mask = 17'h1FFFF;
    repeat (6) @(posedge clk);
    #1 wa_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    chk("arb_grants", grant_log.size(), 6);
    chk("arb_g0_A", grant_log[0], 0);
    chk("arb_g1_B", grant_log[1], 1);
    chk("arb_g2_A", grant_log[2], 0);
    chk("arb_g3_B", grant_log[3], 1);
    rd(5'd20, d);
    chk("arb_b_data", d, {17{8'h3C}});
    n = 0;
    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #1;
      rd_valid = i < 32; rd_addr = 5'(i);
      @(negedge clk);
      if (rsp_valid) n++;
      if (i == 4) chk("b2b_addr3", rsp_data, 136'hFF);
      if (i == 6) chk("b2b_addr5", rsp_data, {8'hFF, 120'h0, 8'hFF});
    end
    chk("b2b_valid_cycles", n, 32);
    @(posedge clk); #1;
    rd_valid = 1'b1; rd_addr = 5'd3;
    @(posedge clk); #1;
    rd_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("inflight_dropped", rsp_valid, 0);
    chk("inflight_data_cleared", rsp_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init(n);
    chk("reinit_write_cycles", n, 32);
    rd(5'd3, d);
    chk("reinit_addr3_zero", d, 136'h0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
